// File: rtl/sdf_r2_butterfly_if.sv
// Sample/twiddle stream into an SDF radix-2 butterfly stage and its result stream.
interface sdf_r2_butterfly_if #(
    parameter int DATA_W = 24
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] din_r;
    logic signed [DATA_W-1:0] din_i;
    logic signed [DATA_W-1:0] w_r;
    logic signed [DATA_W-1:0] w_i;
    logic                     out_valid;
    logic signed [DATA_W-1:0] dout_r;
    logic signed [DATA_W-1:0] dout_i;

    modport master (
        output in_valid, din_r, din_i, w_r, w_i,
        input  out_valid, dout_r, dout_i
    );

    modport slave (
        input  in_valid, din_r, din_i, w_r, w_i,
        output out_valid, dout_r, dout_i
    );
endinterface

// File: rtl/sdf_r2_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage with Q.FRAC twiddle multiply.
// Define SDF_SAT_EN to saturate sums, differences and products instead of wrapping.
module sdf_r2_butterfly #(
    parameter int DATA_W = 24,
    parameter int FRAC   = 8,
    parameter int DELAY  = 2
) (
    input logic                clk,
    input logic                rst,
    sdf_r2_butterfly_if.slave  bus
);
    localparam int CNT_W  = $clog2(2 * DELAY);
    localparam int PROD_W = 2 * DATA_W + 1;
    localparam logic signed [PROD_W-1:0] RND_V =
        {{(PROD_W-1){1'b0}}, 1'b1} << (FRAC - 1);

    function automatic logic signed [PROD_W-1:0] sext_p(input logic [DATA_W-1:0] v);
        return {{(PROD_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

`ifdef SDF_SAT_EN
    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] fit_sum(input logic [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1]) begin
            return v[DATA_W] ? MIN_V : MAX_V;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    function automatic logic [DATA_W-1:0] fit_prod(input logic signed [PROD_W-1:0] v);
        if (v > sext_p(MAX_V)) begin
            return MAX_V;
        end else if (v < sext_p(MIN_V)) begin
            return MIN_V;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction
`endif

    logic                     running_r;
    logic                     primed_r;
    logic [CNT_W-1:0]         ph_cnt_r;
    logic signed [DATA_W-1:0] dl_re_r [DELAY];
    logic signed [DATA_W-1:0] dl_im_r [DELAY];
    logic                     out_valid_r;
    logic signed [DATA_W-1:0] dout_re_r;
    logic signed [DATA_W-1:0] dout_im_r;

    logic                     step_s;
    logic                     bfly_s;
    logic signed [DATA_W-1:0] samp_re_s;
    logic signed [DATA_W-1:0] samp_im_s;
    logic signed [DATA_W-1:0] head_re_s;
    logic signed [DATA_W-1:0] head_im_s;
    logic [DATA_W:0]          sum_re_s;
    logic [DATA_W:0]          sum_im_s;
    logic [DATA_W:0]          dif_re_s;
    logic [DATA_W:0]          dif_im_s;
    logic signed [PROD_W-1:0] prod_re_s;
    logic signed [PROD_W-1:0] prod_im_s;
    logic signed [PROD_W-1:0] shr_re_s;
    logic signed [PROD_W-1:0] shr_im_s;
    logic [DATA_W-1:0]        sum_fit_re_s;
    logic [DATA_W-1:0]        sum_fit_im_s;
    logic [DATA_W-1:0]        dif_fit_re_s;
    logic [DATA_W-1:0]        dif_fit_im_s;
    logic [DATA_W-1:0]        mul_fit_re_s;
    logic [DATA_W-1:0]        mul_fit_im_s;
    logic [DATA_W-1:0]        push_re_s;
    logic [DATA_W-1:0]        push_im_s;
    logic [DATA_W-1:0]        nxt_re_s;
    logic [DATA_W-1:0]        nxt_im_s;

    // Once a frame has started the stream never stalls; missing samples read as zero.
    assign step_s    = bus.in_valid | running_r;
    assign bfly_s    = ph_cnt_r[CNT_W-1];
    assign samp_re_s = bus.in_valid ? bus.din_r : {DATA_W{1'b0}};
    assign samp_im_s = bus.in_valid ? bus.din_i : {DATA_W{1'b0}};
    assign head_re_s = dl_re_r[DELAY-1];
    assign head_im_s = dl_im_r[DELAY-1];

    // Butterfly arithmetic at one guard bit and full-precision rounded twiddle product.
    always_comb begin
        sum_re_s  = {head_re_s[DATA_W-1], head_re_s} + {samp_re_s[DATA_W-1], samp_re_s};
        sum_im_s  = {head_im_s[DATA_W-1], head_im_s} + {samp_im_s[DATA_W-1], samp_im_s};
        dif_re_s  = {head_re_s[DATA_W-1], head_re_s} - {samp_re_s[DATA_W-1], samp_re_s};
        dif_im_s  = {head_im_s[DATA_W-1], head_im_s} - {samp_im_s[DATA_W-1], samp_im_s};
        prod_re_s = sext_p(head_re_s) * sext_p(bus.w_r) - sext_p(head_im_s) * sext_p(bus.w_i);
        prod_im_s = sext_p(head_re_s) * sext_p(bus.w_i) + sext_p(head_im_s) * sext_p(bus.w_r);
        shr_re_s  = (prod_re_s + RND_V) >>> FRAC;
        shr_im_s  = (prod_im_s + RND_V) >>> FRAC;
    end

`ifdef SDF_SAT_EN
    assign sum_fit_re_s = fit_sum(sum_re_s);
    assign sum_fit_im_s = fit_sum(sum_im_s);
    assign dif_fit_re_s = fit_sum(dif_re_s);
    assign dif_fit_im_s = fit_sum(dif_im_s);
    assign mul_fit_re_s = fit_prod(shr_re_s);
    assign mul_fit_im_s = fit_prod(shr_im_s);
`else
    logic unused_wrap_s;
    assign sum_fit_re_s = sum_re_s[DATA_W-1:0];
    assign sum_fit_im_s = sum_im_s[DATA_W-1:0];
    assign dif_fit_re_s = dif_re_s[DATA_W-1:0];
    assign dif_fit_im_s = dif_im_s[DATA_W-1:0];
    assign mul_fit_re_s = shr_re_s[DATA_W-1:0];
    assign mul_fit_im_s = shr_im_s[DATA_W-1:0];
    assign unused_wrap_s = ^{sum_re_s[DATA_W], sum_im_s[DATA_W], dif_re_s[DATA_W],
                             dif_im_s[DATA_W], shr_re_s[PROD_W-1:DATA_W],
                             shr_im_s[PROD_W-1:DATA_W]};
`endif

    // Phase select: FILL stores the sample and rotates the stored difference out.
    always_comb begin
        push_re_s = samp_re_s;
        push_im_s = samp_im_s;
        nxt_re_s  = mul_fit_re_s;
        nxt_im_s  = mul_fit_im_s;
        case (bfly_s)
            1'b0: begin
                push_re_s = samp_re_s;
                push_im_s = samp_im_s;
                nxt_re_s  = mul_fit_re_s;
                nxt_im_s  = mul_fit_im_s;
            end
            1'b1: begin
                push_re_s = dif_fit_re_s;
                push_im_s = dif_fit_im_s;
                nxt_re_s  = sum_fit_re_s;
                nxt_im_s  = sum_fit_im_s;
            end
            default: begin
                push_re_s = samp_re_s;
                push_im_s = samp_im_s;
                nxt_re_s  = mul_fit_re_s;
                nxt_im_s  = mul_fit_im_s;
            end
        endcase
    end

    // Frame control, delay line and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            running_r   <= 1'b0;
            primed_r    <= 1'b0;
            ph_cnt_r    <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            dout_re_r   <= {DATA_W{1'b0}};
            dout_im_r   <= {DATA_W{1'b0}};
            for (int i = 0; i < DELAY; i++) begin
                dl_re_r[i] <= {DATA_W{1'b0}};
                dl_im_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            running_r   <= running_r | bus.in_valid;
            out_valid_r <= step_s & (primed_r | bfly_s);
            if (step_s) begin
                primed_r   <= primed_r | bfly_s;
                ph_cnt_r   <= ph_cnt_r + CNT_W'(1'b1);
                dout_re_r  <= nxt_re_s;
                dout_im_r  <= nxt_im_s;
                dl_re_r[0] <= push_re_s;
                dl_im_r[0] <= push_im_s;
                for (int i = 1; i < DELAY; i++) begin
                    dl_re_r[i] <= dl_re_r[i-1];
                    dl_im_r[i] <= dl_im_r[i-1];
                end
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.dout_r    = dout_re_r;
    assign bus.dout_i    = dout_im_r;
endmodule
